// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the byte-lane mask helper used by both the LSU and the writeback path.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: lane_mask = 4'b0001 << addr_lo;
            F3_LH, F3_LHU: lane_mask = 4'b0011 << addr_lo;
            F3_LW:         lane_mask = 4'b1111;
            default:       lane_mask = 4'b0000;
        endcase
    endfunction

    // Illegal funct3 encodings are folded into the same reject path as misalignment.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = addr_lo[0];
            F3_LW:         misaligned = |addr_lo;
            default:       misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: picks the addressed lane out of a
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'b0, shifted[7:0]};
            F3_LHU:  data_o = {16'b0, shifted[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, lane steering into the data MMU,
// stall-tolerant access with a watchdog, and extended load data back to writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [3:0]  mem_bsel,
    input  logic        mem_nostall,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        exc_misalign,
    output logic        bus_err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             mem_wen_q;
    logic             mem_ren_q;
    logic [3:0]       mem_bsel_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             exc_misalign_q;
    logic             bus_err_q;

    logic             misalign_d;
    logic [3:0]       bsel_d;
    logic [31:0]      wdata_d;
    logic [31:0]      load_d;

    assign misalign_d = misaligned(req_funct3, req_addr[1:0]);
    assign bsel_d     = lane_mask(req_funct3, req_addr[1:0]);

    // Replicate the store operand across every lane so any byte/half offset finds it.
    always_comb begin
        wdata_d = req_wdata;
        case (req_funct3[1:0])
            2'b00:   wdata_d = {4{req_wdata[7:0]}};
            2'b01:   wdata_d = {2{req_wdata[15:0]}};
            default: wdata_d = req_wdata;
        endcase
    end

    lsu_load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (mem_rdata),
        .data_o    (load_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            store_q        <= 1'b0;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wen_q      <= 1'b0;
            mem_ren_q      <= 1'b0;
            mem_bsel_q     <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            exc_misalign_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            rsp_valid_q    <= 1'b0;
            exc_misalign_q <= 1'b0;
            bus_err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        cnt_q     <= '0;
                        if (misalign_d) begin
                            exc_misalign_q <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_bsel_q  <= bsel_d;
                            mem_wdata_q <= wdata_d;
                            mem_wen_q   <= req_store;
                            mem_ren_q   <= !req_store;
                        end
                    end
                end
                ACCESS: begin
                    // Completion is tested first so it beats a watchdog expiry in the same cycle.
                    if (mem_nostall || cnt_q == CNT_LAST) begin
                        mem_addr_q  <= '0;
                        mem_bsel_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wen_q   <= 1'b0;
                        mem_ren_q   <= 1'b0;
                        cnt_q       <= '0;
                        if (mem_nostall) begin
                            rsp_data_q  <= store_q ? 32'b0 : load_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            bus_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wen      = mem_wen_q;
    assign mem_ren      = mem_ren_q;
    assign mem_bsel     = mem_bsel_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign exc_misalign = exc_misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random
// requests plus MMU behaviour, a negedge monitor checks every completion event.
module tb_load_store_unit;

    localparam int WAIT_LIMIT = 16;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [3:0]  mem_bsel;
    logic        mem_nostall;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        exc_misalign;
    logic        bus_err;
    logic        busy;

    load_store_unit #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_bsel     (mem_bsel),
        .mem_nostall  (mem_nostall),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .exc_misalign (exc_misalign),
        .bus_err      (bus_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { K_RSP, K_MIS, K_BUS } kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bsel;
        logic        wen;
        logic        ren;
        int          acc;
        int          busy_n;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // Reference model: derives the whole transaction outcome from the access rules.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int stalls);
        exp_t        e;
        int          nb;
        int          off;
        logic [31:0] v;
        nb       = 1 << f3[1:0];
        off      = int'(addr[1:0]);
        e.kind   = K_MIS;
        e.data   = 32'b0;
        e.addr   = 32'b0;
        e.wdata  = 32'b0;
        e.bsel   = 4'b0;
        e.wen    = 1'b0;
        e.ren    = 1'b0;
        e.acc    = 0;
        e.busy_n = 0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (off % nb) != 0) return e;
        e.addr = addr & 32'hFFFF_FFFC;
        for (int b = 0; b < 4; b++) begin
            e.bsel[b]          = (b >= off) && (b < off + nb);
            e.wdata[8*b +: 8]  = wdata[8*(b % nb) +: 8];
        end
        e.wen = st;
        e.ren = !st;
        if (stalls >= WAIT_LIMIT) begin
            e.kind   = K_BUS;
            e.acc    = WAIT_LIMIT;
            e.busy_n = WAIT_LIMIT;
        end else begin
            e.kind   = K_RSP;
            e.acc    = stalls + 1;
            e.busy_n = stalls + 2;
            if (!st) begin
                v = rdata >> (8 * off);
                if (nb == 1)      e.data = f3[2] ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (nb == 2) e.data = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else              e.data = rdata;
            end
        end
        return e;
    endfunction

    // Monitor
    initial begin : monitor
        int          acc;
        int          busy_n;
        logic        seen;
        logic        bad;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic [3:0]  cap_bsel;
        logic        cap_wen;
        logic        cap_ren;
        logic [31:0] last_rsp;
        logic [2:0]  want;
        exp_t        e;
        acc = 0; busy_n = 0; seen = 1'b0; bad = 1'b0; last_rsp = 32'b0;
        cap_addr = 0; cap_wdata = 0; cap_bsel = 0; cap_wen = 0; cap_ren = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc = 0; busy_n = 0; seen = 1'b0; bad = 1'b0; last_rsp = 32'b0;
            end else begin
                if (busy) busy_n++;
                if (mem_ren || mem_wen) begin
                    if (!seen) begin
                        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_bsel = mem_bsel;
                        cap_wen = mem_wen; cap_ren = mem_ren;
                    end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                                 mem_bsel !== cap_bsel || mem_wen !== cap_wen || mem_ren !== cap_ren) begin
                        bad = 1'b1;
                    end
                    seen = 1'b1;
                    acc++;
                end
                if (rsp_valid || exc_misalign || bus_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {29'b0, rsp_valid, exc_misalign, bus_err}, 32'b0);
                    end else begin
                        e = exp_q.pop_front();
                        case (e.kind)
                            K_RSP:   want = 3'b100;
                            K_MIS:   want = 3'b010;
                            default: want = 3'b001;
                        endcase
                        chk("event_kind", {29'b0, rsp_valid, exc_misalign, bus_err}, {29'b0, want});
                        chk("access_cycles", 32'(acc), 32'(e.acc));
                        chk("busy_cycles", 32'(busy_n), 32'(e.busy_n));
                        chk("ready_vs_busy", {31'b0, req_ready}, {31'b0, !busy});
                        if (e.kind == K_RSP) begin
                            chk("rsp_data", rsp_data, e.data);
                            last_rsp = e.data;
                        end else begin
                            chk("rsp_data_hold", rsp_data, last_rsp);
                        end
                        if (e.kind != K_MIS) begin
                            chk("mem_addr", cap_addr, e.addr);
                            chk("mem_bsel", {28'b0, cap_bsel}, {28'b0, e.bsel});
                            chk("mem_wdata", e.wen ? cap_wdata : 32'b0, e.wdata & {32{e.wen}});
                            chk("mem_wen_ren", {30'b0, cap_wen, cap_ren}, {30'b0, e.wen, e.ren});
                            chk("mem_stable", {31'b0, bad}, 32'b0);
                        end
                    end
                    acc = 0; busy_n = 0; seen = 1'b0; bad = 1'b0;
                end
            end
        end
    end

    task automatic chk_idle(input string p);
        chk({p, "_mem_addr"}, mem_addr, 32'b0);
        chk({p, "_mem_wdata"}, mem_wdata, 32'b0);
        chk({p, "_mem_ctl"}, {26'b0, mem_wen, mem_ren, mem_bsel}, 32'b0);
        chk({p, "_rsp"}, {31'b0, rsp_valid}, 32'b0);
        chk({p, "_rsp_data"}, rsp_data, 32'b0);
        chk({p, "_pulses"}, {30'b0, exc_misalign, bus_err}, 32'b0);
        chk({p, "_ready_busy"}, {30'b0, req_ready, busy}, 32'b10);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'b1);
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stalls, input logic [31:0] rdata);
        exp_t e;
        int   n;
        e = model(st, f3, addr, wdata, rdata, stalls);
        wait_ready();
        exp_q.push_back(e);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        if (e.kind != K_MIS) begin
            n = (stalls >= WAIT_LIMIT) ? WAIT_LIMIT : stalls + 1;
            for (int i = 0; i < n; i++) begin
                mem_nostall = (i == stalls);
                mem_rdata   = (i == stalls) ? rdata : $urandom;
                @(posedge clk); #1;
            end
            mem_nostall = 1'b0;
            mem_rdata   = $urandom;
        end
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r;
        int          stalls;
        int          n;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0; mem_nostall = 1'b0; mem_rdata = 32'b0;
        #12;
        chk_idle("in_reset");
        #10 reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("after_reset");

        do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
        do_op(1'b0, 3'b101, 32'h0000_0202, 32'h0, 3, 32'hBEEF_0000);
        do_op(1'b1, 3'b000, 32'h0000_0005, 32'h0000_00AB, 0, 32'h1234_5678);
        do_op(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0);
        chk("ready_after_misalign", {31'b0, req_ready}, 32'b1);
        do_op(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, WAIT_LIMIT, 32'h0);
        chk("ready_after_bus_err", {31'b0, req_ready}, 32'b1);
        do_op(1'b0, 3'b010, 32'h0000_0020, 32'h0, WAIT_LIMIT - 1, 32'h1357_9BDF);

        // Reset in the middle of a stalled load
        wait_ready();
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_access_ren", {31'b0, mem_ren}, 32'b1);
        #1 reset = 1'b1;
        #1 chk_idle("mid_reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        do_op(1'b0, 3'b010, 32'h0000_0044, 32'h0, 2, 32'hA5A5_0F0F);

        for (int k = 0; k < 250; k++) begin
            st = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 19);
            if (st) f3 = (r == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            else if (r == 0) f3 = 3'd3;
            else if (r == 1) f3 = 3'($urandom_range(6, 7));
            else begin
                r  = $urandom_range(0, 4);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            r = $urandom_range(0, 19);
            if (r < 14)       stalls = $urandom_range(0, 3);
            else if (r < 17)  stalls = $urandom_range(4, 8);
            else if (r == 17) stalls = WAIT_LIMIT - 1;
            else if (r == 18) stalls = WAIT_LIMIT;
            else              stalls = WAIT_LIMIT - 2;
            do_op(st, f3, addr, $urandom, stalls, $urandom);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
